// File: rtl/alu_protocol_monitor_pkg.sv
// Shared types, command constants and decode helpers for the ALU protocol monitor.
package alu_mon_pkg;

  typedef enum int unsigned {
    CHK_RST_OUT  = 0,
    CHK_CMP      = 1,
    CHK_PAIR_TO  = 2,
    CHK_STABLE   = 3,
    CHK_MUL_LAT  = 4,
    CHK_CE_STALL = 5
  } check_e;

  localparam int NUM_CHECKS = 6;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } pair_state_e;

  localparam int unsigned CMP_CMD   = 8;
  localparam int unsigned MUL_CMD_A = 9;
  localparam int unsigned MUL_CMD_B = 10;

  // Commands that consume both operands; single-operand ops are excluded.
  function automatic logic needs_both(input logic mode, input int unsigned cmd);
    if (mode) return !(cmd >= 4 && cmd <= 7);
    else      return !(cmd >= 6 && cmd <= 11);
  endfunction

  function automatic logic is_mul(input int unsigned cmd);
    return (cmd == MUL_CMD_A) || (cmd == MUL_CMD_B);
  endfunction

endpackage

// File: rtl/alu_protocol_monitor_if.sv
// Bundle of ALU port taps; the ALU side drives, the monitor only observes.
interface alu_protocol_monitor_if #(
  parameter int WIDTH     = 8,
  parameter int CMD_WIDTH = 4
) ();
  logic                 rst;
  logic                 ce;
  logic                 mode;
  logic                 cin;
  logic [CMD_WIDTH-1:0] cmd;
  logic [1:0]           inp_valid;
  logic [WIDTH-1:0]     opa;
  logic [WIDTH-1:0]     opb;
  logic [WIDTH:0]       res;
  logic                 cout;
  logic                 oflow;
  logic                 g;
  logic                 l;
  logic                 e;
  logic                 err;

  modport master (
    output rst, ce, mode, cin, cmd, inp_valid, opa, opb,
    output res, cout, oflow, g, l, e, err
  );

  modport slave (
    input rst, ce, mode, cin, cmd, inp_valid, opa, opb,
    input res, cout, oflow, g, l, e, err
  );
endinterface

// File: rtl/alu_protocol_monitor_viol_counter.sv
// Per-check violation bookkeeping: registered pulse, sticky flag, saturating counter.
module viol_counter #(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr,
  input  logic                 hit,
  output logic                 pulse,
  output logic                 flag,
  output logic [CNT_WIDTH-1:0] cnt
);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pulse <= 1'b0;
      flag  <= 1'b0;
      cnt   <= '0;
    end else begin
      pulse <= hit;
      // A hit coincident with clr survives the clear.
      if (clr) begin
        flag <= hit;
        cnt  <= hit ? CNT_WIDTH'(1) : '0;
      end else if (hit) begin
        flag <= 1'b1;
        if (cnt != '1) cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_protocol_monitor.sv
// Passive ALU protocol monitor: six checks, each with pulse, sticky flag and counter.
module alu_protocol_monitor
  import alu_mon_pkg::*;
#(
  parameter int WIDTH        = 8,
  parameter int CMD_WIDTH    = 4,
  parameter int PAIR_TIMEOUT = 16,
  parameter int MUL_LATENCY  = 2,
  parameter int CE_TIMEOUT   = 64,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  alu_protocol_monitor_if.slave alu,
  input  logic                  clr,
  input  logic [2:0]            cnt_sel,
  output logic [NUM_CHECKS-1:0] viol_pulse,
  output logic [NUM_CHECKS-1:0] viol_flag,
  output logic                  any_viol,
  output logic [CNT_WIDTH-1:0]  cnt_rdata
);

  localparam int TW    = $clog2(PAIR_TIMEOUT + 1);
  localparam int CW    = $clog2(CE_TIMEOUT + 1);
  localparam int DEPTH = MUL_LATENCY + 1;

  logic                  en;
  logic                  both_valid;
  logic [NUM_CHECKS-1:0] hit;

  assign en         = !alu.rst && alu.ce;
  assign both_valid = (alu.inp_valid == 2'b11);

  // Reset-output and compare checks
  logic             rst_q;
  logic             cmp_pend_q;
  logic [WIDTH-1:0] opa_q, opb_q;
  logic [2:0]       exp_gle;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_q      <= 1'b0;
      cmp_pend_q <= 1'b0;
      opa_q      <= '0;
      opb_q      <= '0;
    end else begin
      rst_q      <= alu.rst;
      cmp_pend_q <= en && alu.mode && (32'(alu.cmd) == CMP_CMD) && both_valid;
      opa_q      <= alu.opa;
      opb_q      <= alu.opb;
    end
  end

  // Operand-pairing FSM shared by the timeout and stability checks
  pair_state_e          state_q;
  logic [TW-1:0]        timer_q;
  logic [TW-1:0]        timer_next;
  logic [CMD_WIDTH-1:0] cap_cmd_q;
  logic                 cap_mode_q;
  logic                 changed;
  logic                 half_issue;

  assign timer_next = timer_q + 1'b1;
  assign changed    = (alu.cmd != cap_cmd_q) || (alu.mode != cap_mode_q);
  assign half_issue = needs_both(alu.mode, 32'(alu.cmd)) &&
                      (alu.inp_valid == 2'b01 || alu.inp_valid == 2'b10);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      timer_q    <= '0;
      cap_cmd_q  <= '0;
      cap_mode_q <= 1'b0;
    end else if (alu.rst) begin
      state_q <= IDLE;
    end else if (alu.ce) begin
      case (state_q)
        IDLE: if (half_issue) begin
          state_q    <= WAIT;
          cap_cmd_q  <= alu.cmd;
          cap_mode_q <= alu.mode;
          timer_q    <= '0;
        end
        WAIT: begin
          if (changed || both_valid || timer_next == TW'(PAIR_TIMEOUT)) state_q <= IDLE;
          else timer_q <= timer_next;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Multiply latency pipelines
  logic [DEPTH-1:0] mul_pend_q;
  logic [WIDTH:0]   res_pipe_q [DEPTH];
  logic             mul_issue;

  assign mul_issue = en && alu.mode && is_mul(32'(alu.cmd)) && both_valid;

  // NOTE: the RES pipeline is reset with the pending bits so no X ever reaches the compare.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mul_pend_q <= '0;
      for (int i = 0; i < DEPTH; i++) res_pipe_q[i] <= '0;
    end else begin
      res_pipe_q[0] <= alu.res;
      for (int i = 1; i < DEPTH; i++) res_pipe_q[i] <= res_pipe_q[i-1];
      if (alu.rst) begin
        mul_pend_q <= '0;
      end else begin
        mul_pend_q[0] <= mul_issue;
        for (int i = 1; i < DEPTH; i++) mul_pend_q[i] <= mul_pend_q[i-1];
      end
    end
  end

  // CE stall counter holds at the limit so the violation fires once per stall
  logic [CW-1:0] ce_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                           ce_cnt_q <= '0;
    else if (alu.ce)                      ce_cnt_q <= '0;
    else if (ce_cnt_q != CW'(CE_TIMEOUT)) ce_cnt_q <= ce_cnt_q + 1'b1;
  end

  // NOTE: every always_comb output gets a default first, otherwise a latch is inferred.
  always_comb begin
    exp_gle = 3'b001;
    if (opa_q > opb_q)      exp_gle = 3'b100;
    else if (opa_q < opb_q) exp_gle = 3'b010;

    hit = '0;
    hit[CHK_RST_OUT]  = rst_q && ((|alu.res) || alu.cout || alu.oflow ||
                                  alu.g || alu.l || alu.e || alu.err);
    hit[CHK_CMP]      = en && cmp_pend_q && ({alu.g, alu.l, alu.e} != exp_gle);
    hit[CHK_STABLE]   = en && (state_q == WAIT) && changed;
    hit[CHK_PAIR_TO]  = en && (state_q == WAIT) && !changed && !both_valid &&
                        (timer_next == TW'(PAIR_TIMEOUT));
    hit[CHK_MUL_LAT]  = en && mul_pend_q[DEPTH-1] && (alu.res == res_pipe_q[DEPTH-1]);
    hit[CHK_CE_STALL] = !alu.ce && (ce_cnt_q == CW'(CE_TIMEOUT - 1));
  end

  logic [CNT_WIDTH-1:0] cnt_q [NUM_CHECKS];

  for (genvar i = 0; i < NUM_CHECKS; i++) begin : g_chk
    viol_counter #(.CNT_WIDTH(CNT_WIDTH)) u_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (clr),
      .hit   (hit[i]),
      .pulse (viol_pulse[i]),
      .flag  (viol_flag[i]),
      .cnt   (cnt_q[i])
    );
  end

  assign any_viol = |viol_flag;

  always_comb begin
    cnt_rdata = '0;
    if (cnt_sel <= 3'(NUM_CHECKS - 1)) cnt_rdata = cnt_q[cnt_sel];
  end

endmodule
